// File: rtl/k423_mem_lsu.sv
// k423_mem_lsu: single-outstanding load/store unit bridging the EX stage to a data memory port.
// Optional misaligned-access trap is built when K423_LSU_MISALIGN_CHK_EN is defined.
module k423_mem_lsu #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ex_vld_i,
   output logic              ex_rdy_o,
   input  logic              ex_load_i,
   input  logic              ex_unsigned_i,
   input  logic [1:0]        ex_size_i,
   input  logic [XLEN/8-1:0] ex_wen_i,
   input  logic [ADDR_W-1:0] ex_addr_i,
   input  logic [XLEN-1:0]   ex_wdata_i,
   input  logic [4:0]        ex_rd_idx_i,
   output logic              mem_req_vld_o,
   input  logic              mem_req_rdy_i,
   output logic [XLEN/8-1:0] mem_req_wen_o,
   output logic [ADDR_W-1:0] mem_req_addr_o,
   output logic [XLEN-1:0]   mem_req_wdata_o,
   input  logic              mem_rsp_vld_i,
   input  logic [XLEN-1:0]   mem_rsp_rdata_i,
   output logic              wb_vld_o,
   output logic [4:0]        wb_rd_idx_o,
   output logic [XLEN-1:0]   wb_data_o,
   output logic              misalign_o
);

   localparam int unsigned NB = XLEN / 8;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] RESP = 2'd2;
   localparam logic [1:0] WB   = 2'd3;

   logic [1:0]        state_q, state_d;
   logic              load_q, load_d;
   logic              uns_q, uns_d;
   logic [1:0]        size_q, size_d;
   logic [1:0]        off_q, off_d;
   logic [4:0]        rd_q, rd_d;
   logic [NB-1:0]     wen_q, wen_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [4:0]        wb_rd_q, wb_rd_d;
   logic [XLEN-1:0]   wb_data_q, wb_data_d;
   logic              accept;
   logic              misaligned;
   logic [XLEN-1:0]   rsp_sh;
   logic [XLEN-1:0]   load_ext;

   assign accept = ex_vld_i & ex_rdy_o;

`ifdef K423_LSU_MISALIGN_CHK_EN
   logic misalign_q, misalign_d;

   assign misaligned = ((ex_size_i == 2'd1) & ex_addr_i[0]) |
                       (ex_size_i[1] & (ex_addr_i[1:0] != 2'd0));
   assign misalign_d = accept & misaligned;

   always_ff @(posedge clk_i) begin
      if (rst_i) misalign_q <= 1'b0;
      else       misalign_q <= misalign_d;
   end

   assign misalign_o = misalign_q & ~rst_i;
`else
   assign misaligned = 1'b0;
   assign misalign_o = 1'b0;
`endif

   // Size 3 falls through to the word case.
   always_comb begin
      rsp_sh = mem_rsp_rdata_i >> {off_q, 3'b000};
      case (size_q)
         2'd0:    load_ext = {{(XLEN-8){~uns_q & rsp_sh[7]}}, rsp_sh[7:0]};
         2'd1:    load_ext = {{(XLEN-16){~uns_q & rsp_sh[15]}}, rsp_sh[15:0]};
         default: load_ext = mem_rsp_rdata_i;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      load_d    = load_q;
      uns_d     = uns_q;
      size_d    = size_q;
      off_d     = off_q;
      rd_d      = rd_q;
      wen_d     = wen_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               load_d  = ex_load_i;
               uns_d   = ex_unsigned_i;
               size_d  = ex_size_i;
               off_d   = ex_addr_i[1:0];
               rd_d    = ex_rd_idx_i;
               wen_d   = ex_load_i ? '0 : (ex_wen_i << ex_addr_i[1:0]);
               addr_d  = {ex_addr_i[ADDR_W-1:2], 2'b00};
               wdata_d = ex_wdata_i << {ex_addr_i[1:0], 3'b000};
               if (!misaligned) state_d = REQ;
            end
         end
         REQ: begin
            if (mem_req_rdy_i) state_d = load_q ? RESP : IDLE;
         end
         RESP: begin
            if (mem_rsp_vld_i) begin
               state_d   = WB;
               wb_rd_d   = rd_q;
               wb_data_d = load_ext;
            end
         end
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         load_q    <= 1'b0;
         uns_q     <= 1'b0;
         size_q    <= 2'd0;
         off_q     <= 2'd0;
         rd_q      <= 5'd0;
         wen_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wb_rd_q   <= 5'd0;
         wb_data_q <= '0;
      end else begin
         state_q   <= state_d;
         load_q    <= load_d;
         uns_q     <= uns_d;
         size_q    <= size_d;
         off_q     <= off_d;
         rd_q      <= rd_d;
         wen_q     <= wen_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wb_rd_q   <= wb_rd_d;
         wb_data_q <= wb_data_d;
      end
   end

   // Outputs are forced low for the whole reset window, not just after the first edge.
   assign ex_rdy_o        = ~rst_i & (state_q == IDLE);
   assign mem_req_vld_o   = ~rst_i & (state_q == REQ);
   assign mem_req_wen_o   = rst_i ? '0 : wen_q;
   assign mem_req_addr_o  = rst_i ? '0 : addr_q;
   assign mem_req_wdata_o = rst_i ? '0 : wdata_q;
   assign wb_vld_o        = ~rst_i & (state_q == WB) & (wb_rd_q != 5'd0);
   assign wb_rd_idx_o     = rst_i ? 5'd0 : wb_rd_q;
   assign wb_data_o       = rst_i ? '0 : wb_data_q;

endmodule

// File: tb/tb_k423_mem_lsu.sv
// tb_k423_mem_lsu: directed and randomized self-checking bench for k423_mem_lsu (XLEN=ADDR_W=32).
module tb_k423_mem_lsu;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        ex_vld_i, ex_rdy_o, ex_load_i, ex_unsigned_i;
   logic [1:0]  ex_size_i;
   logic [3:0]  ex_wen_i;
   logic [31:0] ex_addr_i, ex_wdata_i;
   logic [4:0]  ex_rd_idx_i;
   logic        mem_req_vld_o, mem_req_rdy_i;
   logic [3:0]  mem_req_wen_o;
   logic [31:0] mem_req_addr_o, mem_req_wdata_o;
   logic        mem_rsp_vld_i;
   logic [31:0] mem_rsp_rdata_i;
   logic        wb_vld_o;
   logic [4:0]  wb_rd_idx_o;
   logic [31:0] wb_data_o;
   logic        misalign_o;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   k423_mem_lsu #(.XLEN(32), .ADDR_W(32)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .ex_vld_i(ex_vld_i), .ex_rdy_o(ex_rdy_o), .ex_load_i(ex_load_i),
      .ex_unsigned_i(ex_unsigned_i), .ex_size_i(ex_size_i), .ex_wen_i(ex_wen_i),
      .ex_addr_i(ex_addr_i), .ex_wdata_i(ex_wdata_i), .ex_rd_idx_i(ex_rd_idx_i),
      .mem_req_vld_o(mem_req_vld_o), .mem_req_rdy_i(mem_req_rdy_i),
      .mem_req_wen_o(mem_req_wen_o), .mem_req_addr_o(mem_req_addr_o),
      .mem_req_wdata_o(mem_req_wdata_o), .mem_rsp_vld_i(mem_rsp_vld_i),
      .mem_rsp_rdata_i(mem_rsp_rdata_i), .wb_vld_o(wb_vld_o), .wb_rd_idx_o(wb_rd_idx_o),
      .wb_data_o(wb_data_o), .misalign_o(misalign_o)
   );

   // Reference: byte offset selects the field, then plain arithmetic extension.
   function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [1:0] size,
                                            input logic uns, input logic [31:0] addr);
      longint unsigned v;
      int unsigned off;
      off = addr % 4;
      if (size >= 2) return rdata;
      v = longint'(rdata) / (64'd1 << (8 * off));
      if (size == 0) begin
         v = v % 256;
         if (!uns && v >= 128) v = v + 64'hFFFF_FF00;
      end else begin
         v = v % 65536;
         if (!uns && v >= 32768) v = v + 64'hFFFF_0000;
      end
      return 32'(v);
   endfunction

   function automatic logic [3:0] ref_wen(input logic [3:0] wen, input logic [31:0] addr,
                                          input logic load);
      if (load) return 4'd0;
      return 4'((int'(wen) * (1 << (addr % 4))) % 16);
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [31:0] wdata, input logic [31:0] addr);
      return 32'((longint'(wdata) * (64'd1 << (8 * (addr % 4)))) % (64'd1 << 32));
   endfunction

   function automatic bit ref_misaligned(input logic [1:0] size, input logic [31:0] addr);
`ifdef K423_LSU_MISALIGN_CHK_EN
      return (size == 1 && addr % 2 == 1) || (size >= 2 && addr % 4 != 0);
`else
      return 1'b0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic ld, input logic uns, input logic [1:0] sz,
                        input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd);
      ex_vld_i = 1'b1; ex_load_i = ld; ex_unsigned_i = uns; ex_size_i = sz;
      ex_wen_i = wen; ex_addr_i = addr; ex_wdata_i = wd; ex_rd_idx_i = rd;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      drive(1'b1, 1'b0, 2'd2, 4'hF, 32'h40, 32'h0, 5'd3);
      tick();
      tick();
      checks++; if (ex_rdy_o !== 1'b0) begin failures++;
         $display("FAIL rst_ex_rdy got=%b exp=0", ex_rdy_o); end
      checks++; if ({mem_req_vld_o, wb_vld_o, misalign_o} !== 3'b000) begin failures++;
         $display("FAIL rst_vld got=%b exp=000", {mem_req_vld_o, wb_vld_o, misalign_o}); end
      checks++; if ({mem_req_addr_o, wb_data_o, wb_rd_idx_o} !== 69'd0) begin failures++;
         $display("FAIL rst_data got=%h exp=0", {mem_req_addr_o, wb_data_o, wb_rd_idx_o}); end
      ex_vld_i = 1'b0;
      rst_i = 1'b0;
      #1;
      checks++; if (ex_rdy_o !== 1'b1) begin failures++;
         $display("FAIL rst_release_rdy got=%b exp=1", ex_rdy_o); end
   endtask

   task automatic test_lb();
      mem_req_rdy_i = 1'b1;
      drive(1'b1, 1'b0, 2'd0, 4'b0001, 32'h103, 32'h0, 5'd5);
      tick();
      ex_vld_i = 1'b0;
      checks++; if (mem_req_vld_o !== 1'b1 || mem_req_addr_o !== 32'h100) begin failures++;
         $display("FAIL lb_req got=%b/%h exp=1/00000100", mem_req_vld_o, mem_req_addr_o); end
      checks++; if (mem_req_wen_o !== 4'd0 || ex_rdy_o !== 1'b0) begin failures++;
         $display("FAIL lb_wen got=%b/%b exp=0000/0", mem_req_wen_o, ex_rdy_o); end
      tick();
      checks++; if (mem_req_vld_o !== 1'b0 || wb_vld_o !== 1'b0) begin failures++;
         $display("FAIL lb_resp got=%b%b exp=00", mem_req_vld_o, wb_vld_o); end
      mem_rsp_vld_i = 1'b1; mem_rsp_rdata_i = 32'h80FF_1234;
      tick();
      mem_rsp_vld_i = 1'b0;
      checks++; if (wb_vld_o !== 1'b1 || wb_rd_idx_o !== 5'd5) begin failures++;
         $display("FAIL lb_wb got=%b/%0d exp=1/5", wb_vld_o, wb_rd_idx_o); end
      checks++; if (wb_data_o !== 32'hFFFF_FF80) begin failures++;
         $display("FAIL lb_data got=%h exp=ffffff80", wb_data_o); end
      tick();
      checks++; if (wb_vld_o !== 1'b0 || ex_rdy_o !== 1'b1 || wb_data_o !== 32'hFFFF_FF80)
         begin failures++;
         $display("FAIL lb_after got=%b%b/%h exp=01/ffffff80", wb_vld_o, ex_rdy_o, wb_data_o); end
      mem_req_rdy_i = 1'b0;
   endtask

   task automatic test_lhu();
      mem_req_rdy_i = 1'b1;
      drive(1'b1, 1'b1, 2'd1, 4'b0011, 32'h102, 32'h0, 5'd9);
      tick();
      ex_vld_i = 1'b0;
      tick();
      mem_rsp_vld_i = 1'b1; mem_rsp_rdata_i = 32'h8001_0000;
      tick();
      mem_rsp_vld_i = 1'b0; mem_req_rdy_i = 1'b0;
      checks++; if (wb_vld_o !== 1'b1 || wb_data_o !== 32'h0000_8001) begin failures++;
         $display("FAIL lhu_data got=%b/%h exp=1/00008001", wb_vld_o, wb_data_o); end
      tick();
   endtask

   task automatic test_sb_stall();
      mem_req_rdy_i = 1'b0;
      drive(1'b0, 1'b0, 2'd0, 4'b0001, 32'h201, 32'h0000_00AB, 5'd0);
      tick();
      ex_vld_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (mem_req_vld_o !== 1'b1 || mem_req_wen_o !== 4'b0010 ||
             mem_req_wdata_o !== 32'h0000_AB00 || mem_req_addr_o !== 32'h200 ||
             ex_rdy_o !== 1'b0 || wb_vld_o !== 1'b0) begin
            failures++;
            $display("FAIL sb_stall_%0d got=%b %b %h %h %b%b exp=1 0010 0000ab00 00000200 00",
                     k, mem_req_vld_o, mem_req_wen_o, mem_req_wdata_o, mem_req_addr_o,
                     ex_rdy_o, wb_vld_o);
         end
         if (k == 3) mem_req_rdy_i = 1'b1;
         tick();
      end
      mem_req_rdy_i = 1'b0;
      checks++; if ({mem_req_vld_o, ex_rdy_o, wb_vld_o} !== 3'b010) begin failures++;
         $display("FAIL sb_done got=%b exp=010", {mem_req_vld_o, ex_rdy_o, wb_vld_o}); end
      tick();
      checks++; if (wb_vld_o !== 1'b0) begin failures++;
         $display("FAIL sb_no_wb got=%b exp=0", wb_vld_o); end
   endtask

   task automatic test_lw_rd0_stray();
      mem_rsp_vld_i = 1'b1; mem_rsp_rdata_i = 32'hDEAD_BEEF;
      tick();
      mem_rsp_vld_i = 1'b0;
      checks++; if ({wb_vld_o, ex_rdy_o, mem_req_vld_o} !== 3'b010 || wb_data_o !== 32'h8001)
         begin failures++;
         $display("FAIL stray_rsp got=%b/%h exp=010/00008001",
                  {wb_vld_o, ex_rdy_o, mem_req_vld_o}, wb_data_o); end
      mem_req_rdy_i = 1'b1;
      drive(1'b1, 1'b0, 2'd2, 4'hF, 32'h300, 32'h0, 5'd0);
      tick();
      ex_vld_i = 1'b0;
      checks++; if (mem_req_vld_o !== 1'b1 || mem_req_addr_o !== 32'h300) begin failures++;
         $display("FAIL lw_rd0_req got=%b/%h exp=1/00000300", mem_req_vld_o, mem_req_addr_o); end
      tick();
      mem_rsp_vld_i = 1'b1; mem_rsp_rdata_i = 32'h1234_5678;
      tick();
      mem_rsp_vld_i = 1'b0; mem_req_rdy_i = 1'b0;
      checks++; if (wb_vld_o !== 1'b0) begin failures++;
         $display("FAIL lw_rd0_wb got=%b exp=0", wb_vld_o); end
      tick();
      checks++; if (ex_rdy_o !== 1'b1) begin failures++;
         $display("FAIL lw_rd0_idle got=%b exp=1", ex_rdy_o); end
   endtask

   task automatic test_reset_in_resp();
      mem_req_rdy_i = 1'b1;
      drive(1'b1, 1'b0, 2'd2, 4'hF, 32'h400, 32'h0, 5'd7);
      tick();
      ex_vld_i = 1'b0; mem_req_rdy_i = 1'b0;
      tick();
      rst_i = 1'b1;
      #1;
      checks++; if (ex_rdy_o !== 1'b0 || wb_data_o !== 32'd0) begin failures++;
         $display("FAIL rst_resp_hold got=%b/%h exp=0/00000000", ex_rdy_o, wb_data_o); end
      tick();
      rst_i = 1'b0;
      mem_rsp_vld_i = 1'b1; mem_rsp_rdata_i = 32'hCAFE_F00D;
      #1;
      checks++; if (ex_rdy_o !== 1'b1) begin failures++;
         $display("FAIL rst_resp_release got=%b exp=1", ex_rdy_o); end
      tick();
      mem_rsp_vld_i = 1'b0;
      checks++; if ({wb_vld_o, ex_rdy_o, mem_req_vld_o} !== 3'b010) begin failures++;
         $display("FAIL rst_resp_late got=%b exp=010", {wb_vld_o, ex_rdy_o, mem_req_vld_o}); end
   endtask

   task automatic test_misalign();
      mem_req_rdy_i = 1'b1;
      drive(1'b1, 1'b0, 2'd2, 4'hF, 32'h102, 32'h0, 5'd4);
      tick();
      ex_vld_i = 1'b0;
`ifdef K423_LSU_MISALIGN_CHK_EN
      checks++; if ({misalign_o, mem_req_vld_o, ex_rdy_o} !== 3'b101) begin failures++;
         $display("FAIL misalign_pulse got=%b exp=101", {misalign_o, mem_req_vld_o, ex_rdy_o}); end
      tick();
      checks++; if ({misalign_o, mem_req_vld_o, wb_vld_o} !== 3'b000) begin failures++;
         $display("FAIL misalign_end got=%b exp=000", {misalign_o, mem_req_vld_o, wb_vld_o}); end
`else
      checks++; if ({misalign_o, mem_req_vld_o} !== 2'b01 || mem_req_addr_o !== 32'h100) begin
         failures++;
         $display("FAIL misalign_off got=%b/%h exp=01/00000100",
                  {misalign_o, mem_req_vld_o}, mem_req_addr_o); end
      tick();
      mem_rsp_vld_i = 1'b1; mem_rsp_rdata_i = 32'hA5A5_0F0F;
      tick();
      mem_rsp_vld_i = 1'b0;
      checks++; if (wb_vld_o !== 1'b1 || wb_data_o !== 32'hA5A5_0F0F) begin failures++;
         $display("FAIL misalign_off_wb got=%b/%h exp=1/a5a50f0f", wb_vld_o, wb_data_o); end
      tick();
`endif
      mem_req_rdy_i = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] wd;
      wd = $urandom;
      mem_req_rdy_i = 1'b1;
      drive(1'b0, 1'b0, 2'd2, 4'hF, 32'h500, wd, 5'd0);
      tick();
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (mem_req_vld_o !== (k % 2 == 0) || ex_rdy_o !== (k % 2 == 1) ||
             (k % 2 == 0 && mem_req_wdata_o !== wd)) begin
            failures++;
            $display("FAIL b2b_%0d got=%b%b/%h exp=%b%b/%h", k, mem_req_vld_o, ex_rdy_o,
                     mem_req_wdata_o, k % 2 == 0, k % 2 == 1, wd);
         end
         if (k == 5) ex_vld_i = 1'b0;
         tick();
      end
      mem_req_rdy_i = 1'b0;
   endtask

   task automatic test_random();
      logic        ld, uns, mis;
      logic [1:0]  sz;
      logic [3:0]  wen;
      logic [31:0] addr, wd, rdata;
      logic [4:0]  rd;
      int          rwait, dwait;
      for (int n = 0; n < 60; n++) begin
         ld = 1'($urandom); uns = 1'($urandom); sz = 2'($urandom);
         wen = (sz == 0) ? 4'b0001 : (sz == 1) ? 4'b0011 : 4'b1111;
         addr = $urandom; wd = $urandom; rd = 5'($urandom); rdata = $urandom;
         rwait = $urandom_range(0, 3); dwait = $urandom_range(0, 3);
         mis = ref_misaligned(sz, addr);
         checks++; if (ex_rdy_o !== 1'b1) begin failures++;
            $display("FAIL rnd_rdy_%0d got=%b exp=1", n, ex_rdy_o); end
         drive(ld, uns, sz, wen, addr, wd, rd);
         mem_req_rdy_i = 1'b0;
         tick();
         ex_vld_i = 1'b0;
         if (mis) begin
            checks++; if ({misalign_o, mem_req_vld_o} !== 2'b10) begin failures++;
               $display("FAIL rnd_mis_%0d got=%b exp=10", n, {misalign_o, mem_req_vld_o}); end
            tick();
            continue;
         end
         for (int k = 0; k <= rwait; k++) begin
            checks++;
            if (mem_req_vld_o !== 1'b1 || misalign_o !== 1'b0 ||
                mem_req_addr_o !== {addr[31:2], 2'b00} ||
                mem_req_wen_o !== ref_wen(wen, addr, ld) ||
                (!ld && mem_req_wdata_o !== ref_wdata(wd, addr))) begin
               failures++;
               $display("FAIL rnd_req_%0d got=%b %h %b %h exp=1 %h %b %h", n, mem_req_vld_o,
                        mem_req_addr_o, mem_req_wen_o, mem_req_wdata_o, {addr[31:2], 2'b00},
                        ref_wen(wen, addr, ld), ref_wdata(wd, addr));
            end
            mem_req_rdy_i = (k == rwait);
            tick();
         end
         mem_req_rdy_i = 1'b0;
         if (!ld) begin
            checks++; if ({mem_req_vld_o, ex_rdy_o, wb_vld_o} !== 3'b010) begin failures++;
               $display("FAIL rnd_st_%0d got=%b exp=010", n, {mem_req_vld_o, ex_rdy_o, wb_vld_o});
            end
            continue;
         end
         for (int k = 0; k < dwait; k++) tick();
         mem_rsp_vld_i = 1'b1; mem_rsp_rdata_i = rdata;
         tick();
         mem_rsp_vld_i = 1'b0;
         checks++;
         if (wb_vld_o !== (rd != 0) || wb_rd_idx_o !== rd ||
             wb_data_o !== ref_load(rdata, sz, uns, addr)) begin
            failures++;
            $display("FAIL rnd_ld_%0d got=%b %0d %h exp=%b %0d %h", n, wb_vld_o, wb_rd_idx_o,
                     wb_data_o, rd != 0, rd, ref_load(rdata, sz, uns, addr));
         end
         tick();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rst_i = 1'b1; ex_vld_i = 1'b0; ex_load_i = 1'b0; ex_unsigned_i = 1'b0;
      ex_size_i = 2'd0; ex_wen_i = 4'd0; ex_addr_i = 32'd0; ex_wdata_i = 32'd0;
      ex_rd_idx_i = 5'd0; mem_req_rdy_i = 1'b0; mem_rsp_vld_i = 1'b0; mem_rsp_rdata_i = 32'd0;
      test_reset();
      test_lb();
      test_lhu();
      test_sb_stall();
      test_lw_rd0_stray();
      test_reset_in_resp();
      test_misalign();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/k423_mem_lsu.md
K423_MEM_LSU -- requirements
Module: k423_mem_lsu

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, data path width.
REQ-002 The block SHALL have parameter ADDR_W, default 32, address width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; clk_i and rst_i are fixed by that decision.
REQ-004 The block SHALL have clk_i  in  1  clock, all state on rising edge.
REQ-005 The block SHALL have rst_i  in  1  synchronous active-high reset.
REQ-006 The block SHALL have ex_vld_i  in  1  EX-stage memory op valid.
REQ-007 The block SHALL have ex_rdy_o  out  1  block can accept an op.
REQ-008 The block SHALL have ex_load_i  in  1  op is a load (else store).
REQ-009 The block SHALL have ex_unsigned_i  in  1  zero-extend load result.
REQ-010 The block SHALL have ex_size_i  in  2  access size: 0 byte, 1 half, 2 word; 3 is treated as word.
REQ-011 The block SHALL have ex_wen_i  in  XLEN/8  unshifted byte enables (0001/0011/1111).
REQ-012 The block SHALL have ex_addr_i  in  ADDR_W  effective address.
REQ-013 The block SHALL have ex_wdata_i  in  XLEN  unshifted store data.
REQ-014 The block SHALL have ex_rd_idx_i  in  5  load destination register.
REQ-015 The block SHALL have mem_req_vld_o / mem_req_rdy_i  out/in  1  data memory request handshake.
REQ-016 The block SHALL have mem_req_wen_o  out  XLEN/8  lane byte enables, all 0 for loads.
REQ-017 The block SHALL have mem_req_addr_o  out  ADDR_W  word address, low 2 bits forced 0.
REQ-018 The block SHALL have mem_req_wdata_o  out  XLEN  lane-aligned store data.
REQ-019 The block SHALL have mem_rsp_vld_i  in  1  read data valid, single cycle.
REQ-020 The block SHALL have mem_rsp_rdata_i  in  XLEN  read word.
REQ-021 The block SHALL have wb_vld_o  out  1  one-cycle writeback pulse.
REQ-022 The block SHALL have wb_rd_idx_o  out  5  writeback register.
REQ-023 The block SHALL have wb_data_o  out  XLEN  extended load result.
REQ-024 The block SHALL have misalign_o  out  1  one-cycle misaligned-access pulse.

Function
REQ-025 The FSM SHALL have states IDLE, REQ, RESP and WB; ex_rdy_o SHALL be 1 only in IDLE.
REQ-026 On ex_vld_i&ex_rdy_o the block SHALL register all ex_* fields and enter REQ next cycle.
REQ-027 In REQ, mem_req_vld_o SHALL be 1 and all mem_req_* SHALL stay stable until mem_req_rdy_i.
REQ-028 On REQ acceptance, a store SHALL return to IDLE and produce no writeback; a load SHALL enter RESP.
REQ-029 Store lanes SHALL be wen<<addr[1:0] and wdata<<(8*addr[1:0]); bits shifted beyond XLEN SHALL be dropped.
REQ-030 In RESP, on mem_rsp_vld_i the block SHALL register rdata>>(8*addr[1:0]), sign- or zero-extended from bit 7 (byte) or bit 15 (half); a word SHALL use rdata unshifted. The FSM SHALL then enter WB.
REQ-031 In WB, wb_vld_o SHALL be 1 for exactly one cycle, except when wb_rd_idx_o==0, where it SHALL stay 0; the FSM SHALL then return to IDLE.
REQ-032 mem_rsp_vld_i outside RESP SHALL be ignored.
REQ-033 Minimum load latency SHALL be: accept at cycle N, mem_req_vld_o at N+1, response no earlier than N+2, wb_vld_o at N+3; zero-wait store throughput is one op per 2 cycles.
REQ-034 wb_rd_idx_o and wb_data_o SHALL hold their last value outside WB.

Reset
REQ-035 While rst_i is 1 the FSM SHALL be IDLE, ex_rdy_o SHALL be 0, and all other outputs SHALL be 0; ex_rdy_o SHALL be 1 the first cycle after release.
REQ-036 Reset asserted in REQ or RESP SHALL abort the op; a response arriving after reset SHALL be ignored.

Configuration
REQ-037 With K423_LSU_MISALIGN_CHK_EN defined, an accepted half with addr[0]=1 or a word with addr[1:0]!=0 SHALL pulse misalign_o the next cycle and stay IDLE, with no memory request and no writeback.
REQ-038 Without K423_LSU_MISALIGN_CHK_EN, misalign_o SHALL be tied 0 and misaligned ops SHALL proceed per REQ-029/030 with truncation.

Verification
REQ-039 The bench SHALL cover: LB addr 0x103, rdata 0x80FF_1234, rd=5, rdy=1 at once -> mem_req_addr_o 0x100, wb_vld_o at N+3, wb_data_o 0xFFFF_FF80.
REQ-040 The bench SHALL cover: LHU addr 0x102, rdata 0x8001_0000 -> wb_data_o 0x0000_8001.
REQ-041 The bench SHALL cover: SB addr 0x201, wdata 0xAB, rdy held 0 for 3 cycles -> mem_req_wen_o 0010 and mem_req_wdata_o 0x0000_AB00 stable 4 cycles, ex_rdy_o 0 throughout, no wb_vld_o.
REQ-042 The bench SHALL cover: LW rd=0 -> memory read issued, wb_vld_o stays 0; stray mem_rsp_vld_i in IDLE -> no effect.
REQ-043 The bench SHALL cover: rst_i asserted during RESP, response the next cycle -> no wb_vld_o, ex_rdy_o 1 after release.
REQ-044 The bench SHALL cover, with K423_LSU_MISALIGN_CHK_EN: LW addr 0x102 -> misalign_o one-cycle pulse, mem_req_vld_o stays 0.
